// File: rtl/cv32e40p_ft_breakage_monitor.sv
// Breakage monitor for the triplicated IF-stage submodules: leaky error counters per replica,
// sticky broken flags, vote-failure flags and (with CV32E40P_FT_BREAKAGE_REPORT_EN) a serialised event report.
//
// state | meaning
// IDLE  | no event presented; picks the lowest pending replica when one exists
// SEND  | event held on report_mod_o/report_rep_o until report_ready_i
module cv32e40p_ft_breakage_monitor #(
    parameter int unsigned N_MOD              = 6,
    parameter int unsigned INCREMENT          = 1,
    parameter int unsigned DECREMENT          = 1,
    parameter int unsigned BREAKING_THRESHOLD = 3,
    parameter int unsigned COUNT_BIT          = 8,
    parameter int unsigned INC_DEC_BIT        = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_MOD-1:0]           chk_i,
    input  logic [3*N_MOD-1:0]         err_i,
    input  logic [N_MOD-1:0]           clear_i,
    output logic [3*N_MOD-1:0]         broken_o,
    output logic [N_MOD-1:0]           mod_fail_o,
    output logic                       any_fail_o,
    output logic                       report_valid_o,
    input  logic                       report_ready_i,
    output logic [$clog2(N_MOD)-1:0]   report_mod_o,
    output logic [1:0]                 report_rep_o
);

    localparam int unsigned N_REP = 3 * N_MOD;
    localparam int unsigned MOD_W = $clog2(N_MOD);

    localparam logic [INC_DEC_BIT-1:0] INC_W   = INC_DEC_BIT'(INCREMENT);
    localparam logic [INC_DEC_BIT-1:0] DEC_W   = INC_DEC_BIT'(DECREMENT);
    localparam logic [COUNT_BIT:0]     INC_X   = (COUNT_BIT+1)'(INC_W);
    localparam logic [COUNT_BIT:0]     DEC_X   = (COUNT_BIT+1)'(DEC_W);
    localparam logic [COUNT_BIT:0]     CNT_MAX = {1'b0, {COUNT_BIT{1'b1}}};

    logic [N_REP-1:0][COUNT_BIT-1:0] cnt_vec;
    logic [N_REP-1:0]                broken_q;
    logic [N_REP-1:0]                brk_rise;

    for (genvar g = 0; g < N_REP; g++) begin : g_rep
        localparam int unsigned M = g / 3;

        logic [COUNT_BIT-1:0] cnt_q;
        logic                 brk_q;
        logic [COUNT_BIT:0]   sum;
        logic [COUNT_BIT:0]   diff;
        logic [COUNT_BIT-1:0] upd;
        logic                 hit;
        logic                 step;

        // Arithmetic is one bit wider so overflow/borrow can be clamped instead of wrapping.
        always_comb begin
            sum  = {1'b0, cnt_q} + INC_X;
            diff = {1'b0, cnt_q} - DEC_X;
            if (err_i[g]) begin
                upd = (sum > CNT_MAX) ? CNT_MAX[COUNT_BIT-1:0] : sum[COUNT_BIT-1:0];
            end else begin
                upd = diff[COUNT_BIT] ? '0 : diff[COUNT_BIT-1:0];
            end
            hit  = 32'(upd) >= BREAKING_THRESHOLD;
            step = !clear_i[M] && !brk_q && chk_i[M];
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q <= '0;
                brk_q <= 1'b0;
            end else if (clear_i[M]) begin
                cnt_q <= '0;
                brk_q <= 1'b0;
            end else if (step) begin
                cnt_q <= upd;
                if (hit) begin
                    brk_q <= 1'b1;
                end
            end
        end

        assign cnt_vec[g]  = cnt_q;
        assign broken_q[g] = brk_q;
        assign brk_rise[g] = step && hit;
    end

    for (genvar m = 0; m < N_MOD; m++) begin : g_mod
        logic a, b, c;
        assign a = broken_q[3*m];
        assign b = broken_q[3*m+1];
        assign c = broken_q[3*m+2];
        assign mod_fail_o[m] = (a & b) | (a & c) | (b & c);
    end

    assign broken_o   = broken_q;
    assign any_fail_o = |mod_fail_o;

`ifdef CV32E40P_FT_BREAKAGE_REPORT_EN

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } rpt_state_e;

    rpt_state_e       state_q, state_d;
    logic [N_REP-1:0] pend_q, pend_d;
    logic [N_REP-1:0] clr_rep;
    logic [MOD_W-1:0] rmod_q, rmod_d;
    logic [1:0]       rrep_q, rrep_d;

    logic             sel_found;
    logic [MOD_W-1:0] sel_mod;
    logic [1:0]       sel_rep;
    logic [N_REP-1:0] sel_onehot;

    for (genvar g = 0; g < N_REP; g++) begin : g_clr
        assign clr_rep[g] = clear_i[g/3];
    end

    // Scanning downwards leaves the lowest flat index as the winner.
    always_comb begin
        sel_found  = 1'b0;
        sel_mod    = '0;
        sel_rep    = '0;
        sel_onehot = '0;
        for (int i = N_REP - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_found     = 1'b1;
                sel_mod       = MOD_W'(i / 3);
                sel_rep       = 2'(i % 3);
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        rmod_d  = rmod_q;
        rrep_d  = rrep_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d = SEND;
                    rmod_d  = sel_mod;
                    rrep_d  = sel_rep;
                    pend_d  = pend_d & ~sel_onehot;
                end
            end
            SEND: begin
                if (report_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        pend_d = (pend_d & ~clr_rep) | brk_rise;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            rmod_q  <= '0;
            rrep_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            rmod_q  <= rmod_d;
            rrep_q  <= rrep_d;
        end
    end

    assign report_valid_o = (state_q == SEND);
    assign report_mod_o   = rmod_q;
    assign report_rep_o   = rrep_q;

`else

    logic unused_report;
    assign unused_report = report_ready_i | (|brk_rise);

    assign report_valid_o = 1'b0;
    assign report_mod_o   = '0;
    assign report_rep_o   = '0;

`endif

endmodule
